bus_timer: RTL and testbench
============================

// Module: bus_timer
// PURPOSE
//  Memory-mapped down-counter on the CPU data bus (m_data_addr/m_data_wdata/m_data_byteen side).
//  Drives the CPU interrupt input. The system bridge selects it by address.
//  Software programs PRESET and CTRL. Counting, reload and IRQ generation run autonomously.
// PARAMETERS
//  BASE_ADDR  32'h0000_7F00  byte base of the 3-word register window (16-byte aligned)
// PORTS
//  clk      in   1   system clock, rising edge
//  reset    in   1   asynchronous, active-low; all state cleared while low
//  addr     in   32  byte address from CPU data port
//  wdata    in   32  write data
//  byteen   in   4   per-byte write strobe; 4'b0000 = no write
//  rdata    out  32  read data, combinational from addr
//  irq      out  1   interrupt request to CPU
// BEHAVIOUR
//  Register map (addr[3:2]; hit = addr[31:4]==BASE_ADDR[31:4], addr[3:2]!=3):
//   0 CTRL   [0] EN, [2:1] MODE (0 one-shot, 1 auto-reload, 2/3 = one-shot), [3] IM; [31:4] read 0
//   1 PRESET 32-bit reload value
//   2 COUNT  read-only current count; writes ignored
//  Write: on posedge clk when hit & |byteen; only enabled bytes merge into the register.
//  Read: rdata = selected register when hit, else 32'h0. addr[1:0] ignored.
//  Reset values: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0, irq=0, rdata per addr.
//  FSM (one register, 2 bits):
//   IDLE: EN=1 -> LOAD.
//   LOAD: COUNT<=PRESET -> CNT.
//   CNT : EN=0 -> IDLE. COUNT==0 -> INT. Otherwise COUNT<=COUNT-1.
//   INT : mode 1 -> LOAD. Mode 0/2/3 -> IDLE and CTRL.EN<=0, in the same edge.
//  Count arithmetic: 32-bit unsigned. No decrement below 0. PRESET=0 gives LOAD->CNT->INT.
//  Timing: CTRL write with EN=1 at edge E0 -> LOAD state after E1 -> COUNT=PRESET after E2.
//   COUNT reaches 0 after E2+N -> INT after E2+N+1.
//  irq_flag:
//   - Set on the edge that enters INT.
//   - Mode 0: sticky until any CTRL write (any byteen).
//   - Mode 1: cleared on the next edge (1-cycle pulse).
//   - irq = irq_flag & IM, registered. No combinational path from bus to irq.
//  Simultaneous events:
//   - A CTRL write in the same edge as an FSM EN clear: the bus write wins.
//   - A CTRL write in the same edge as the irq_flag set: the set wins.
//   - A PRESET write during CNT affects only the next LOAD.
//   - Clearing EN in INT: INT exit completes as normal, then IDLE.
//  Reset mid-count: async return to reset values. No pending irq survives.
// STRUCTURE
//  Package bus_timer_pkg holds:
//   - offsets OFF_CTRL=2'd0, OFF_PRESET=2'd1, OFF_COUNT=2'd2
//   - CTRL bit indices EN_BIT, MODE_LSB, IM_BIT
//   - MODE_ONESHOT, MODE_RELOAD
//   - state enum {IDLE, LOAD, CNT, INT}
//  One sub-module, byte_merge, is natural: old word + wdata + byteen -> merged word.
//  It is shared by the CTRL and PRESET write paths.
//  Single clock domain. No other hierarchy.
// TESTING
//  1. Reset low mid-count (COUNT=7, state CNT) -> all regs 0 and irq=0 immediately; IDLE after release.
//  2. PRESET=5, CTRL=4'b1001 (one-shot, IM) -> COUNT reads 5,4,3,2,1,0.
//     irq=1 from 8 cycles after the CTRL edge; CTRL.EN reads 0. irq stays high until CTRL is rewritten.
//  3. PRESET=3, CTRL=4'b1011 (auto-reload) -> irq 1-cycle pulse every 6 cycles over at least 4 periods.
//  4. PRESET written 32'h0000_0000, then byteen=4'b0010 with wdata=32'hAABBCCDD.
//     -> PRESET reads 32'h0000_CC00. A write to COUNT leaves COUNT unchanged.
//  5. Mid-count, CTRL=0 written -> next edge IDLE, COUNT frozen, no irq.
//     PRESET=0 with EN -> irq after LOAD/CNT/INT (3 edges).
//  6. addr = BASE_ADDR+12 or outside the window with byteen=4'hF -> no register change, rdata=0.

Source files
------------

// File: rtl/bus_timer_pkg.sv
// Shared definitions for the bus timer: register offsets, CTRL bit layout,
// counting modes and the FSM state encoding.
package bus_timer_pkg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 4;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  localparam int EN_BIT   = 0;
  localparam int MODE_LSB = 1;
  localparam int IM_BIT   = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_e;

endpackage

// File: rtl/bus_timer_if.sv
// CPU data-bus view of the timer: address/write side from the CPU,
// read data and interrupt back to it.
interface bus_timer_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byteen;
  logic [31:0] rdata;
  logic        irq;

  modport master (output addr, output wdata, output byteen, input rdata, input irq);
  modport slave  (input addr, input wdata, input byteen, output rdata, output irq);
endinterface

// File: rtl/bus_timer_byte_merge.sv
// Merges a write word into an existing register value, one byte lane per
// byteen bit.
module bus_timer_byte_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (byteen[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped 32-bit down-counter with one-shot / auto-reload modes and a
// registered interrupt output.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  bus_timer_if.slave  bus
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] preset_q, preset_d;
  logic [DATA_W-1:0] count_q, count_d;
  state_e            state_q, state_d;
  logic              irq_flag_q, irq_flag_d;
  logic              irq_q, irq_d;

  logic [1:0]        off;
  logic              hit, wr_ctrl, wr_preset;
  logic [DATA_W-1:0] old_word, merged, rdata;
  logic [1:0]        mode;
  logic              en, enter_int, fsm_en_clr;
  logic              addr_unused;

  assign off         = bus.addr[3:2];
  assign addr_unused = ^bus.addr[1:0];
  assign hit         = (bus.addr[31:4] == BASE_ADDR[31:4]) && (off != 2'd3);
  assign wr_ctrl     = hit && (|bus.byteen) && (off == OFF_CTRL);
  assign wr_preset   = hit && (|bus.byteen) && (off == OFF_PRESET);

  // CTRL and PRESET never receive a write in the same cycle, so one merger serves both.
  assign old_word = (off == OFF_CTRL) ? {{(DATA_W-CTRL_W){1'b0}}, ctrl_q} : preset_q;

  bus_timer_byte_merge u_byte_merge (
    .old_word (old_word),
    .wdata    (bus.wdata),
    .byteen   (bus.byteen),
    .merged   (merged)
  );

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (off)
        OFF_CTRL:   rdata = {{(DATA_W-CTRL_W){1'b0}}, ctrl_q};
        OFF_PRESET: rdata = preset_q;
        OFF_COUNT:  rdata = count_q;
        default:    rdata = '0;
      endcase
    end
  end

  assign bus.rdata = rdata;
  assign bus.irq   = irq_q;

  assign mode = ctrl_q[MODE_LSB +: 2];
  assign en   = ctrl_q[EN_BIT];

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    irq_flag_d = irq_flag_q;
    enter_int  = 1'b0;
    fsm_en_clr = 1'b0;

    case (state_q)
      IDLE: if (en) state_d = LOAD;
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!en) begin
          state_d = IDLE;
        end else if (count_q == '0) begin
          state_d   = INT;
          enter_int = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      INT: begin
        if (mode == MODE_RELOAD) begin
          state_d = LOAD;
        end else begin
          state_d    = IDLE;
          fsm_en_clr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus writes are applied after the FSM's EN clear so software wins a collision.
    if (fsm_en_clr) ctrl_d[EN_BIT] = 1'b0;
    if (wr_ctrl)    ctrl_d = merged[CTRL_W-1:0];
    if (wr_preset)  preset_d = merged;

    // Priority low to high: reload pulse clear, CTRL-write clear, INT entry set.
    if (irq_flag_q && (mode == MODE_RELOAD)) irq_flag_d = 1'b0;
    if (wr_ctrl)                             irq_flag_d = 1'b0;
    if (enter_int)                           irq_flag_d = 1'b1;

    irq_d = irq_flag_d & ctrl_d[IM_BIT];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
      irq_q      <= irq_d;
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer: register-access vector table plus hand-timed
// counting, reload, collision and reset sequences.
module tb_bus_timer;

  localparam logic [31:0] BASE   = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL = BASE;
  localparam logic [31:0] A_PRE  = BASE + 32'd4;
  localparam logic [31:0] A_CNT  = BASE + 32'd8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  bus_timer_if bus ();

  bus_timer #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    bus.addr   = a;
    bus.wdata  = d;
    bus.byteen = be;
    @(posedge clk);
    #1;
    bus.byteen = 4'b0000;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus.addr   = a;
    bus.byteen = 4'b0000;
    #1;
    check(name, bus.rdata, exp);
  endtask

  task automatic chk_irq(input string name, input logic exp);
    check(name, {31'b0, bus.irq}, {31'b0, exp});
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    bus.addr   = '0;
    bus.wdata  = '0;
    bus.byteen = 4'b0000;
    reset      = 1'b0;

    // Register access vectors, starting from reset with the timer idle.
    vecs[0]  = '{A_PRE,           32'h0000_0000, 4'b1111, A_PRE,           32'h0000_0000};
    vecs[1]  = '{A_PRE,           32'hAABB_CCDD, 4'b0010, A_PRE,           32'h0000_CC00};
    vecs[2]  = '{A_PRE,           32'h1122_3344, 4'b0001, A_PRE,           32'h0000_CC44};
    vecs[3]  = '{A_PRE,           32'h5566_7788, 4'b1100, A_PRE,           32'h5566_CC44};
    vecs[4]  = '{A_CNT,           32'hFFFF_FFFF, 4'b1111, A_CNT,           32'h0000_0000};
    vecs[5]  = '{A_CTRL,          32'hFFFF_FFFE, 4'b1111, A_CTRL,          32'h0000_000E};
    vecs[6]  = '{BASE + 32'd12,   32'hFFFF_FFFF, 4'b1111, BASE + 32'd12,   32'h0000_0000};
    vecs[7]  = '{32'h0000_8F04,   32'h0000_0000, 4'b1111, A_PRE,           32'h5566_CC44};
    vecs[8]  = '{32'h0001_7F04,   32'hFFFF_FFFF, 4'b1111, 32'h0000_7E04,   32'h0000_0000};
    vecs[9]  = '{BASE + 32'd3,    32'h0000_0006, 4'b1111, A_CTRL,          32'h0000_0006};
    vecs[10] = '{A_CTRL,          32'h0000_0000, 4'b0001, A_CTRL,          32'h0000_0000};
    vecs[11] = '{A_PRE,           32'h0000_0000, 4'b0000, BASE + 32'd7,    32'h5566_CC44};

    // Reset state, sampled while reset is held low.
    #2;
    chk_reg("rst_ctrl",   A_CTRL, 32'h0);
    chk_reg("rst_preset", A_PRE,  32'h0);
    chk_reg("rst_count",  A_CNT,  32'h0);
    chk_irq("rst_irq", 1'b0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      wr(vecs[i].waddr, vecs[i].wdata, vecs[i].be);
      chk_reg($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
    end
    chk_irq("vec_irq", 1'b0);

    // Reset asserted mid-count.
    wr(A_PRE, 32'd10, 4'b1111);
    wr(A_CTRL, 32'h9, 4'b1111);
    tick(2);
    chk_reg("t1_load", A_CNT, 32'd10);
    tick(3);
    chk_reg("t1_cnt7", A_CNT, 32'd7);
    #2;
    reset = 1'b0;
    #1;
    chk_irq("t1_rst_irq", 1'b0);
    chk_reg("t1_rst_ctrl", A_CTRL, 32'h0);
    chk_reg("t1_rst_pre",  A_PRE,  32'h0);
    chk_reg("t1_rst_cnt",  A_CNT,  32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick(3);
    chk_reg("t1_idle_cnt", A_CNT, 32'h0);
    chk_irq("t1_idle_irq", 1'b0);

    // One-shot countdown with a sticky interrupt.
    wr(A_PRE, 32'd5, 4'b1111);
    wr(A_CTRL, 32'h9, 4'b1111);
    tick(2);
    chk_reg("t2_cnt5", A_CNT, 32'd5);
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      chk_reg($sformatf("t2_cnt%0d", 5 - k), A_CNT, 32'(5 - k));
      chk_irq($sformatf("t2_noirq%0d", k), 1'b0);
    end
    tick(1);
    chk_irq("t2_irq_at8", 1'b1);
    tick(1);
    chk_reg("t2_en_clr", A_CTRL, 32'h8);
    chk_irq("t2_irq_hold", 1'b1);
    tick(3);
    chk_irq("t2_irq_sticky", 1'b1);
    chk_reg("t2_cnt_hold", A_CNT, 32'h0);
    wr(A_CTRL, 32'h8, 4'b1111);
    chk_irq("t2_irq_clr", 1'b0);

    // Auto-reload: one-cycle pulse every PRESET+3 cycles.
    wr(A_PRE, 32'd3, 4'b1111);
    wr(A_CTRL, 32'hB, 4'b1111);
    for (int k = 1; k <= 26; k++) begin
      tick(1);
      chk_irq($sformatf("t3_k%0d", k), (k % 6) == 0);
    end
    wr(A_CTRL, 32'h0, 4'b1111);
    chk_irq("t3_stop", 1'b0);
    tick(2);

    // Disable mid-count freezes COUNT.
    wr(A_PRE, 32'd20, 4'b1111);
    wr(A_CTRL, 32'h9, 4'b1111);
    tick(2);
    chk_reg("t5_cnt20", A_CNT, 32'd20);
    tick(3);
    chk_reg("t5_cnt17", A_CNT, 32'd17);
    wr(A_CTRL, 32'h0, 4'b1111);
    chk_reg("t5_cnt16", A_CNT, 32'd16);
    tick(3);
    chk_reg("t5_frozen", A_CNT, 32'd16);
    chk_irq("t5_noirq", 1'b0);

    // PRESET=0: LOAD, CNT, INT.
    wr(A_PRE, 32'd0, 4'b1111);
    wr(A_CTRL, 32'h9, 4'b1111);
    tick(1);
    chk_irq("t5_z1", 1'b0);
    tick(1);
    chk_irq("t5_z2", 1'b0);
    tick(1);
    chk_irq("t5_z3", 1'b1);

    // CTRL write on the INT exit edge: bus value kept, flag cleared, restart.
    wr(A_CTRL, 32'h9, 4'b1111);
    chk_reg("c1_ctrl_wins", A_CTRL, 32'h9);
    chk_irq("c1_irq_clr", 1'b0);
    tick(1);
    chk_irq("c1_r1", 1'b0);
    tick(1);
    chk_irq("c1_r2", 1'b0);
    tick(1);
    chk_irq("c1_r3", 1'b1);
    tick(1);
    chk_reg("c1_en_clr", A_CTRL, 32'h8);
    chk_irq("c1_sticky", 1'b1);

    // Pending interrupt does not survive reset.
    #2;
    reset = 1'b0;
    #1;
    chk_irq("c1_rst_irq", 1'b0);
    chk_reg("c1_rst_ctrl", A_CTRL, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // CTRL write on the edge that enters INT: the set wins.
    wr(A_CTRL, 32'h9, 4'b1111);
    tick(2);
    wr(A_CTRL, 32'h9, 4'b1111);
    chk_irq("c2_set_wins", 1'b1);
    tick(1);
    chk_reg("c2_en_clr", A_CTRL, 32'h8);
    chk_irq("c2_hold", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
